// File: rtl/regfile_pkg.sv
// Shared types for the regfile writeback arbiter: requester identifiers
// and the requester count.
package regfile_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Grant is combinational from req and the
// last granted requester; last_grant only moves when advance is high.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    req_id_t r_last_grant;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (r_last_grant == REQ_LSU) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Reset to LSU so the ALU wins the first contested cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= REQ_LSU;
        end else if (advance) begin
            r_last_grant <= grant[1] ? REQ_LSU : REQ_ALU;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU and LSU writeback with a
// registered output stage, and tracks pending writes per register.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int n = 16,
    parameter int r = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    input  logic [2*r-1:0]     req_addr,
    input  logic [2*n-1:0]     req_data,
    output logic [1:0]         req_ready,
    input  logic               rsv_valid,
    input  logic [r-1:0]       rsv_addr,
    input  logic [r-1:0]       ra1,
    input  logic [r-1:0]       ra2,
    output logic               busy1,
    output logic               busy2,
    output logic               stall,
    output logic               we3,
    output logic [r-1:0]       wa3,
    output logic [n-1:0]       wd3
);

    logic [NUM_REQ-1:0] w_grant;
    logic               w_accept;
    logic [r-1:0]       w_sel_addr;
    logic [n-1:0]       w_sel_data;
    logic [2**r-1:0]    r_busy;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (w_accept),
        .grant   (w_grant)
    );

    assign w_accept   = (|w_grant) && !reset;
    assign req_ready  = reset ? '0 : w_grant;
    assign w_sel_addr = w_grant[1] ? req_addr[2*r-1:r] : req_addr[r-1:0];
    assign w_sel_data = w_grant[1] ? req_data[2*n-1:n] : req_data[n-1:0];

    // Writes to register 0 are accepted but never reach the regfile.
    always_ff @(posedge clk) begin
        if (reset) begin
            we3 <= 1'b0;
            wa3 <= '0;
            wd3 <= '0;
        end else if (w_accept) begin
            we3 <= (w_sel_addr != '0);
            wa3 <= w_sel_addr;
            wd3 <= w_sel_data;
        end else begin
            we3 <= 1'b0;
        end
    end

    // A new reservation beats a retiring write to the same register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            for (int unsigned i = 1; i < (1 << r); i++) begin
                if (rsv_valid && (rsv_addr == r'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (we3 && (wa3 == r'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
            r_busy[0] <= 1'b0;
        end
    end

    assign busy1 = r_busy[ra1];
    assign busy2 = r_busy[ra2];
    assign stall = busy1 | busy2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table,
// hand-written reset sequences and a randomized run against a reference model.
module tb_regfile_wb_arbiter;

    localparam int N = 16;
    localparam int R = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req_valid;
    logic [2*R-1:0] req_addr;
    logic [2*N-1:0] req_data;
    logic [1:0]     req_ready;
    logic           rsv_valid;
    logic [R-1:0]   rsv_addr, ra1, ra2;
    logic           busy1, busy2, stall, we3;
    logic [R-1:0]   wa3;
    logic [N-1:0]   wd3;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.n(N), .r(R)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .ra1       (ra1),
        .ra2       (ra2),
        .busy1     (busy1),
        .busy2     (busy2),
        .stall     (stall),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    typedef struct {
        logic [1:0]  vld;
        logic [2:0]  a0, a1;
        logic [15:0] d0, d1;
        logic        rv;
        logic [2:0]  ra, rd1, rd2;
        logic [1:0]  rdy;
        logic        b1, b2, we;
        logic [2:0]  wa;
        logic [15:0] wd;
    } vec_t;

    vec_t tbl[15];

    // Reference model state
    int          m_last;
    bit          m_busy[8];
    bit          m_we;
    logic [2:0]  m_wa;
    logic [15:0] m_wd;

    logic [2:0]  a0, a1;
    logic [15:0] d0, d1;
    bit          pend0, pend1;

    task automatic drive(input logic [1:0] v, input logic [2:0] x0, input logic [2:0] x1,
                         input logic [15:0] y0, input logic [15:0] y1, input logic rv,
                         input logic [2:0] ra, input logic [2:0] s1, input logic [2:0] s2);
        req_valid = v;
        req_addr  = {x1, x0};
        req_data  = {y1, y0};
        rsv_valid = rv;
        rsv_addr  = ra;
        ra1       = s1;
        ra2       = s2;
    endtask

    initial begin
        drive(2'b11, 3'd1, 3'd2, 16'h1111, 16'h2222, 1'b0, 3'd0, 3'd0, 3'd0);
        reset = 1'b1;

        // Reset held two cycles with both requesters asserting.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("reset_ready", 32'(req_ready), 32'd0);
            chk("reset_stall", 32'(stall), 32'd0);
            @(posedge clk); #1;
            chk("reset_we3", 32'(we3), 32'd0);
            chk("reset_wa3", 32'(wa3), 32'd0);
            chk("reset_wd3", 32'(wd3), 32'd0);
        end

        tbl[0]  = '{2'b01, 3'd3, 3'd0, 16'h1234, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0, 2'b01, 1'b0, 1'b0, 1'b1, 3'd3, 16'h1234};
        tbl[1]  = '{2'b11, 3'd1, 3'd2, 16'hAAAA, 16'hBBBB, 1'b0, 3'd0, 3'd0, 3'd0, 2'b10, 1'b0, 1'b0, 1'b1, 3'd2, 16'hBBBB};
        tbl[2]  = '{2'b11, 3'd1, 3'd2, 16'hAAAA, 16'hBBBB, 1'b0, 3'd0, 3'd0, 3'd0, 2'b01, 1'b0, 1'b0, 1'b1, 3'd1, 16'hAAAA};
        tbl[3]  = '{2'b11, 3'd1, 3'd2, 16'hAAAA, 16'hBBBB, 1'b0, 3'd0, 3'd0, 3'd0, 2'b10, 1'b0, 1'b0, 1'b1, 3'd2, 16'hBBBB};
        tbl[4]  = '{2'b11, 3'd1, 3'd2, 16'hAAAA, 16'hBBBB, 1'b0, 3'd0, 3'd0, 3'd0, 2'b01, 1'b0, 1'b0, 1'b1, 3'd1, 16'hAAAA};
        tbl[5]  = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b1, 3'd5, 3'd5, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000};
        tbl[6]  = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd0, 2'b00, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000};
        tbl[7]  = '{2'b10, 3'd0, 3'd5, 16'h0000, 16'h5555, 1'b0, 3'd0, 3'd5, 3'd0, 2'b10, 1'b1, 1'b0, 1'b1, 3'd5, 16'h5555};
        tbl[8]  = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd0, 2'b00, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000};
        tbl[9]  = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000};
        tbl[10] = '{2'b10, 3'd0, 3'd5, 16'h0000, 16'h6666, 1'b0, 3'd0, 3'd5, 3'd0, 2'b10, 1'b0, 1'b0, 1'b1, 3'd5, 16'h6666};
        tbl[11] = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b1, 3'd5, 3'd5, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000};
        tbl[12] = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 3'd0, 3'd5, 3'd0, 2'b00, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000};
        tbl[13] = '{2'b10, 3'd0, 3'd0, 16'h0000, 16'h7777, 1'b1, 3'd0, 3'd0, 3'd5, 2'b10, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000};
        tbl[14] = '{2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd5, 2'b00, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000};

        reset = 1'b0;
        foreach (tbl[k]) begin
            drive(tbl[k].vld, tbl[k].a0, tbl[k].a1, tbl[k].d0, tbl[k].d1,
                  tbl[k].rv, tbl[k].ra, tbl[k].rd1, tbl[k].rd2);
            @(negedge clk);
            chk($sformatf("v%0d_ready", k), 32'(req_ready), 32'(tbl[k].rdy));
            chk($sformatf("v%0d_busy1", k), 32'(busy1), 32'(tbl[k].b1));
            chk($sformatf("v%0d_busy2", k), 32'(busy2), 32'(tbl[k].b2));
            chk($sformatf("v%0d_stall", k), 32'(stall), 32'(tbl[k].b1 | tbl[k].b2));
            @(posedge clk); #1;
            chk($sformatf("v%0d_we3", k), 32'(we3), 32'(tbl[k].we));
            if (tbl[k].we) begin
                chk($sformatf("v%0d_wa3", k), 32'(wa3), 32'(tbl[k].wa));
                chk($sformatf("v%0d_wd3", k), 32'(wd3), 32'(tbl[k].wd));
            end
        end

        // Reset arriving while a write sits in the output stage.
        drive(2'b01, 3'd4, 3'd0, 16'hABCD, 16'h0000, 1'b1, 3'd6, 3'd6, 3'd0);
        @(posedge clk); #1;
        chk("mid_we3_pre", 32'(we3), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_ready_in_reset", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(2'b00, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 3'd0, 3'd6, 3'd4);
        chk("mid_we3_dropped", 32'(we3), 32'd0);
        @(negedge clk);
        chk("mid_busy_cleared", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("mid_no_late_write", 32'(we3), 32'd0);

        // Randomized run from a fresh reset against the reference model.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_last = 1;
        foreach (m_busy[b]) m_busy[b] = 1'b0;
        m_we = 1'b0; m_wa = '0; m_wd = '0;
        pend0 = 1'b0; pend1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        req_valid = 2'b00;

        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [1:0] v;
            int         g;
            logic [1:0] exp_rdy;
            bit         rv;
            logic [2:0] ra;
            v = req_valid;
            if (!pend0) begin
                v[0] = 1'($urandom_range(0, 1));
                a0 = 3'($urandom);
                d0 = 16'($urandom);
            end
            if (!pend1) begin
                v[1] = 1'($urandom_range(0, 1));
                a1 = 3'($urandom);
                d1 = 16'($urandom);
            end
            rv = ($urandom_range(0, 3) == 0);
            ra = 3'($urandom);
            drive(v, a0, a1, d0, d1, rv, ra, 3'($urandom), 3'($urandom));

            if (v == 2'b11)      g = (m_last == 1) ? 0 : 1;
            else if (v == 2'b01) g = 0;
            else if (v == 2'b10) g = 1;
            else                 g = -1;
            exp_rdy = (g < 0) ? 2'b00 : 2'(1 << g);

            @(negedge clk);
            chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rnd_busy1", 32'(busy1), 32'(m_busy[ra1]));
            chk("rnd_busy2", 32'(busy2), 32'(m_busy[ra2]));
            chk("rnd_stall", 32'(stall), 32'(m_busy[ra1] | m_busy[ra2]));

            @(posedge clk);
            if (m_we) m_busy[m_wa] = 1'b0;
            if (rv && ra != 3'd0) m_busy[ra] = 1'b1;
            if (g >= 0) begin
                m_wa   = (g == 1) ? a1 : a0;
                m_wd   = (g == 1) ? d1 : d0;
                m_we   = (m_wa != 3'd0);
                m_last = g;
            end else begin
                m_we = 1'b0;
            end
            pend0 = v[0] && (g != 0);
            pend1 = v[1] && (g != 1);
            #1;
            chk("rnd_we3", 32'(we3), 32'(m_we));
            if (m_we) begin
                chk("rnd_wa3", 32'(wa3), 32'(m_wa));
                chk("rnd_wd3", 32'(wd3), 32'(m_wd));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
